// File: rtl/vga_pic_bounce.sv
// vga_pic_bounce: 8-bar RGB565 test pattern with a square block that moves
// one step per frame and bounces off the active-area edges.
// Optional feature macro: BOUNCE_COLOUR_CYCLE_EN (block colour steps through
// the palette on every frame that contains a wall hit).
module vga_pic_bounce #(
    parameter int unsigned H_VALID  = 640,
    parameter int unsigned V_VALID  = 480,
    parameter int unsigned BLK_SIZE = 32,
    parameter int unsigned STEP     = 2,
    parameter int unsigned BAR_W    = 80
) (
    input  logic        Clk_int,
    input  logic        Sys_Rst_n,
    input  logic        V_sys,
    input  logic [9:0]  jpg_x,
    input  logic [9:0]  jpg_y,
    input  logic        move_en,
    output logic [15:0] jpg_colour,
    output logic        frame_tick,
    output logic [7:0]  hit_cnt
);

    // Direction state: bit0 = moving left, bit1 = moving up
    localparam logic [1:0] DR = 2'b00;
    localparam logic [1:0] DL = 2'b01;
    localparam logic [1:0] UR = 2'b10;
    localparam logic [1:0] UL = 2'b11;

    localparam logic [10:0] X_LIM  = 11'(H_VALID - BLK_SIZE);
    localparam logic [10:0] Y_LIM  = 11'(V_VALID - BLK_SIZE);
    localparam logic [10:0] STEP_W = 11'(STEP);
    localparam logic [10:0] BLK_W  = 11'(BLK_SIZE);
    localparam logic [9:0]  BAR_WW = 10'(BAR_W);

    typedef struct packed {
        logic [9:0] pos;
        logic       neg;
        logic       hit;
    } axis_t;

    logic        v_d1;
    logic [9:0]  blk_x;
    logic [9:0]  blk_y;
    logic [1:0]  dir_state;
    logic        update;
    axis_t       x_nxt;
    axis_t       y_nxt;
    logic        any_hit;
    logic [15:0] blk_colour;
    logic        in_blk;
    logic [9:0]  bar_q;
    logic [2:0]  bar_idx;

    // One axis of bounce motion; compares are 11 bits wide so pos+STEP never wraps
    function automatic axis_t axis_step(input logic [9:0] pos, input logic neg,
                                        input logic [10:0] lim);
        axis_t      r;
        logic [10:0] p;
        logic [10:0] s;
        p = {1'b0, pos};
        r.neg = neg;
        r.hit = 1'b0;
        if (!neg) begin
            s = p + STEP_W;
            if (s >= lim) begin
                r.pos = lim[9:0];
                r.neg = 1'b1;
                r.hit = 1'b1;
            end else begin
                r.pos = s[9:0];
            end
        end else begin
            s = p - STEP_W;
            if (p <= STEP_W) begin
                r.pos = '0;
                r.neg = 1'b0;
                r.hit = 1'b1;
            end else begin
                r.pos = s[9:0];
            end
        end
        return r;
    endfunction

    function automatic logic [15:0] palette(input logic [2:0] idx);
        logic [15:0] c;
        case (idx)
            3'd0:    c = 16'hFFFF;
            3'd1:    c = 16'hFFE0;
            3'd2:    c = 16'h07FF;
            3'd3:    c = 16'h07E0;
            3'd4:    c = 16'hF81F;
            3'd5:    c = 16'hF800;
            3'd6:    c = 16'h001F;
            default: c = 16'h0000;
        endcase
        return c;
    endfunction

    // Frame-start detect: v_d1 resets high so no tick fires while V_sys is high out of reset
    always_ff @(posedge Clk_int or negedge Sys_Rst_n) begin
        if (!Sys_Rst_n) begin
            v_d1       <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            v_d1       <= V_sys;
            frame_tick <= V_sys & ~v_d1;
        end
    end

    assign update = frame_tick & move_en;

    // Next block position and direction for both axes
    always_comb begin
        x_nxt   = axis_step(blk_x, dir_state[0], X_LIM);
        y_nxt   = axis_step(blk_y, dir_state[1], Y_LIM);
        any_hit = x_nxt.hit | y_nxt.hit;
    end

    // Block state advances only once per frame, so a frame never shows a partial move
    always_ff @(posedge Clk_int or negedge Sys_Rst_n) begin
        if (!Sys_Rst_n) begin
            blk_x     <= '0;
            blk_y     <= '0;
            dir_state <= DR;
            hit_cnt   <= '0;
        end else if (update) begin
            blk_x     <= x_nxt.pos;
            blk_y     <= y_nxt.pos;
            dir_state <= {y_nxt.neg, x_nxt.neg};
            if (any_hit) begin
                hit_cnt <= hit_cnt + 8'd1;
            end
        end
    end

`ifdef BOUNCE_COLOUR_CYCLE_EN
    logic [2:0] colour_idx;

    // Block colour steps through the palette on every frame that bumps hit_cnt
    always_ff @(posedge Clk_int or negedge Sys_Rst_n) begin
        if (!Sys_Rst_n) begin
            colour_idx <= '0;
        end else if (update && any_hit) begin
            colour_idx <= colour_idx + 3'd1;
        end
    end

    assign blk_colour = palette(colour_idx);
`else
    assign blk_colour = 16'h7BEF;
`endif

    // Zero-latency pixel colour: block overlays the bars; x past the last bar clamps to black
    always_comb begin
        in_blk = ({1'b0, jpg_x} >= {1'b0, blk_x}) &&
                 ({1'b0, jpg_x} <  ({1'b0, blk_x} + BLK_W)) &&
                 ({1'b0, jpg_y} >= {1'b0, blk_y}) &&
                 ({1'b0, jpg_y} <  ({1'b0, blk_y} + BLK_W));
        bar_q   = jpg_x / BAR_WW;
        bar_idx = (bar_q > 10'd7) ? 3'd7 : bar_q[2:0];
        if (in_blk) begin
            jpg_colour = blk_colour;
        end else begin
            jpg_colour = palette(bar_idx);
        end
    end

    // DL/UR/UL are named for readability of the direction encoding
    logic unused_states;
    assign unused_states = ^{DL, UR, UL};

endmodule

// File: tb/tb_vga_pic_bounce.sv
// Testbench for vga_pic_bounce: behavioural bounce model with randomized
// frames, move_en and pixel probes. Honors BOUNCE_COLOUR_CYCLE_EN.
module tb_vga_pic_bounce;

    logic        Clk_int;
    logic        Sys_Rst_n;
    logic        V_sys;
    logic [9:0]  jpg_x;
    logic [9:0]  jpg_y;
    logic        move_en;
    logic [15:0] jpg_colour;
    logic        frame_tick;
    logic [7:0]  hit_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state (plain integers)
    int m_x, m_y, m_dx, m_dy, m_hits, m_cidx;
    logic [15:0] pal [8];

    vga_pic_bounce #(
        .H_VALID(640), .V_VALID(480), .BLK_SIZE(32), .STEP(2), .BAR_W(80)
    ) dut (
        .Clk_int(Clk_int),
        .Sys_Rst_n(Sys_Rst_n),
        .V_sys(V_sys),
        .jpg_x(jpg_x),
        .jpg_y(jpg_y),
        .move_en(move_en),
        .jpg_colour(jpg_colour),
        .frame_tick(frame_tick),
        .hit_cnt(hit_cnt)
    );

    initial Clk_int = 1'b0;
    always #5 Clk_int = ~Clk_int;

    function automatic void model_reset();
        m_x = 0; m_y = 0; m_dx = 1; m_dy = 1; m_hits = 0; m_cidx = 0;
    endfunction

    function automatic void model_frame(input logic en);
        bit hit;
        hit = 0;
        if (!en) return;
        if (m_dx > 0) begin
            if (m_x + 2 >= 608) begin m_x = 608; m_dx = -1; hit = 1; end
            else m_x = m_x + 2;
        end else begin
            if (m_x <= 2) begin m_x = 0; m_dx = 1; hit = 1; end
            else m_x = m_x - 2;
        end
        if (m_dy > 0) begin
            if (m_y + 2 >= 448) begin m_y = 448; m_dy = -1; hit = 1; end
            else m_y = m_y + 2;
        end else begin
            if (m_y <= 2) begin m_y = 0; m_dy = 1; hit = 1; end
            else m_y = m_y - 2;
        end
        if (hit) begin
            m_hits = (m_hits + 1) % 256;
            m_cidx = (m_cidx + 1) % 8;
        end
    endfunction

    function automatic logic [15:0] model_blk();
`ifdef BOUNCE_COLOUR_CYCLE_EN
        return pal[m_cidx];
`else
        return 16'h7BEF;
`endif
    endfunction

    function automatic logic [15:0] model_colour(input int x, input int y);
        int idx;
        if (x >= m_x && x < m_x + 32 && y >= m_y && y < m_y + 32)
            return model_blk();
        idx = x / 80;
        if (idx > 7) idx = 7;
        return pal[idx];
    endfunction

    task automatic probe(input string name, input int x, input int y);
        logic [15:0] exp_c;
        @(negedge Clk_int);
        jpg_x = 10'(x);
        jpg_y = 10'(y);
        #1;
        exp_c = model_colour(x, y);
        tests_run++;
        if (jpg_colour !== exp_c) begin
            tests_failed++;
            $display("FAIL %s x=%0d y=%0d colour got %h want %h", name, x, y, jpg_colour, exp_c);
        end
    endtask

    // Probes the block outline so any positional error shows up in the colour
    task automatic check_block(input string name);
        probe(name, m_x, m_y);
        probe(name, m_x + 31, m_y + 31);
        probe(name, m_x + 32, m_y);
        probe(name, m_x, m_y + 32);
        if (m_x > 0) probe(name, m_x - 1, m_y + 5);
        if (m_y > 0) probe(name, m_x + 5, m_y - 1);
        tests_run++;
        if (hit_cnt !== 8'(m_hits)) begin
            tests_failed++;
            $display("FAIL %s hit_cnt got %0d want %0d", name, hit_cnt, m_hits);
        end
    endtask

    // One frame: V_sys low then high, expect exactly one frame_tick
    task automatic run_frame(input logic en);
        int ticks;
        @(negedge Clk_int);
        move_en = en;
        V_sys = 1'b0;
        repeat (2 + $urandom_range(0, 2)) @(negedge Clk_int);
        V_sys = 1'b1;
        ticks = 0;
        repeat (4) begin
            @(negedge Clk_int);
            if (frame_tick === 1'b1) ticks++;
        end
        model_frame(en);
        tests_run++;
        if (ticks !== 1) begin
            tests_failed++;
            $display("FAIL frame_tick_count got %0d want 1", ticks);
        end
    endtask

    task automatic test_reset();
        int ticks;
        Sys_Rst_n = 1'b0; V_sys = 1'b1; move_en = 1'b1; jpg_x = '0; jpg_y = '0;
        model_reset();
        repeat (3) @(negedge Clk_int);
        Sys_Rst_n = 1'b1;
        probe("reset_blk", 10, 10);
        probe("reset_bar1", 100, 200);
        probe("reset_x639", 639, 0);
        probe("reset_x640", 640, 0);
        probe("reset_x1023", 1023, 300);
        ticks = 0;
        repeat (10) begin
            @(negedge Clk_int);
            if (frame_tick !== 1'b0) ticks++;
        end
        tests_run++;
        if (ticks !== 0) begin
            tests_failed++;
            $display("FAIL reset_no_tick got %0d ticks want 0", ticks);
        end
        tests_run++;
        if (hit_cnt !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset_hit_cnt got %0d want 0", hit_cnt);
        end
    endtask

    task automatic test_first_frame();
        run_frame(1'b1);
        probe("first_blk_33", 33, 33);
        probe("first_bar_1", 1, 1);
        probe("first_blk_2", 2, 2);
        check_block("first_outline");
    endtask

    task automatic test_bounce();
        logic [15:0] before_c;
        repeat (222) run_frame(1'b1);
        check_block("pre_hit");
        before_c = model_blk();
        run_frame(1'b1);
        check_block("y_hit");
        probe("y_hit_blk_colour", m_x + 10, m_y + 10);
        tests_run++;
        if (m_y !== 448 || m_x !== 448 || m_hits !== 1) begin
            tests_failed++;
            $display("FAIL model_frame224 x=%0d y=%0d hits=%0d want 448 448 1", m_x, m_y, m_hits);
        end
        if (before_c !== model_blk()) probe("colour_step", m_x + 3, m_y + 3);
        repeat (80) run_frame(1'b1);
        check_block("x_hit");
    endtask

    task automatic test_freeze();
        repeat (10) run_frame(1'b0);
        check_block("frozen");
        run_frame(1'b1);
        check_block("resume");
    endtask

    task automatic test_async_reset();
        @(negedge Clk_int);
        jpg_x = 10'd300; jpg_y = 10'd100;
        #2;
        Sys_Rst_n = 1'b0;
        model_reset();
        #1;
        tests_run++;
        if (hit_cnt !== 8'd0 || frame_tick !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset hit_cnt=%0d tick=%b want 0 0", hit_cnt, frame_tick);
        end
        jpg_x = 10'd0; jpg_y = 10'd0;
        #1;
        tests_run++;
        if (jpg_colour !== model_colour(0, 0)) begin
            tests_failed++;
            $display("FAIL async_reset_colour got %h want %h", jpg_colour, model_colour(0, 0));
        end
        jpg_x = 10'd40; jpg_y = 10'd40;
        #1;
        tests_run++;
        if (jpg_colour !== model_colour(40, 40)) begin
            tests_failed++;
            $display("FAIL async_reset_outside got %h want %h", jpg_colour, model_colour(40, 40));
        end
        @(negedge Clk_int);
        Sys_Rst_n = 1'b1;
        check_block("after_reset");
    endtask

    task automatic test_random();
        for (int f = 0; f < 400; f++) begin
            run_frame(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
            if (f % 8 == 0) begin
                for (int k = 0; k < 4; k++)
                    probe("rand_pix", $urandom_range(0, 1023), $urandom_range(0, 1023));
                probe("rand_near", m_x + $urandom_range(0, 40), m_y + $urandom_range(0, 40));
                check_block("rand_outline");
            end
        end
    endtask

    initial begin
        pal[0] = 16'hFFFF; pal[1] = 16'hFFE0; pal[2] = 16'h07FF; pal[3] = 16'h07E0;
        pal[4] = 16'hF81F; pal[5] = 16'hF800; pal[6] = 16'h001F; pal[7] = 16'h0000;
        test_reset();
        test_first_frame();
        test_bounce();
        test_freeze();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
